// File: rtl/dvp_pixel_packer_if.sv
// AXI4-Stream style video bus shared by the byte input and the pixel output of dvp_pixel_packer.
interface dvp_pixel_packer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/dvp_pixel_packer.sv
// Pairs DVP bytes into 16-bit pixels, buffers them in a FIFO for a back-pressured AXIS master,
// drops on overflow, realigns on SOF and keeps line/frame statistics.
module dvp_pixel_packer #(
  parameter int BYTE_SWAP  = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic                pclk,
  input  logic                rst,
  dvp_pixel_packer_if.slave   s_axis,
  dvp_pixel_packer_if.master  m_axis,
  input  logic                clear_status,
  output logic                overflow,
  output logic                align_err,
  output logic [CNT_W-1:0]    line_pixels,
  output logic [CNT_W-1:0]    frame_lines
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FIRST    = 2'd1,
    SECOND   = 2'd2,
    DROP     = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r;
  logic [7:0]       first_r;
  logic             sof_pend_r;
  logic [17:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             tvalid_r;
  logic             overflow_r;
  logic             align_err_r;
  logic [CNT_W-1:0] pix_cnt_r;
  logic [CNT_W-1:0] line_cnt_r;
  logic [CNT_W-1:0] line_pixels_r;
  logic [CNT_W-1:0] frame_lines_r;

  logic             pop_s;
  logic             full_s;
  logic             pix_vld_s;
  logic             push_s;
  logic             drop_s;
  logic             align_set_s;
  logic [15:0]      pix_data_s;
  logic [AW:0]      count_nxt_s;
  logic [17:0]      rd_word_s;
  logic [CNT_W-1:0] pix_inc_s;
  logic [CNT_W-1:0] line_base_s;

  assign pop_s       = tvalid_r & m_axis.tready;
  assign full_s      = (count_r == DEPTH_C);
  assign pix_vld_s   = s_axis.tvalid && (state_r == SECOND) && !s_axis.tuser;
  // A full FIFO still takes the pixel when the head leaves in the same cycle.
  assign push_s      = pix_vld_s && (!full_s || pop_s);
  assign drop_s      = pix_vld_s && !push_s;
  assign align_set_s = s_axis.tvalid &&
                       (((state_r == FIRST) && s_axis.tlast) ||
                        ((state_r == SECOND) && s_axis.tuser));
  assign rd_word_s   = mem_r[rd_ptr_r];
  assign pix_inc_s   = sat_inc(pix_cnt_r);
  assign line_base_s = sof_pend_r ? {CNT_W{1'b0}} : line_cnt_r;

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = tvalid_r;
  assign overflow      = overflow_r;
  assign align_err     = align_err_r;
  assign line_pixels   = line_pixels_r;
  assign frame_lines   = frame_lines_r;

  // Byte order of the packed pixel.
  always_comb begin
    if (BYTE_SWAP != 0) pix_data_s = {s_axis.tdata, first_r};
    else                pix_data_s = {first_r, s_axis.tdata};
  end

  // Next FIFO occupancy.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Output fields are forced to zero while no pixel is presented.
  always_comb begin
    if (tvalid_r) begin
      m_axis.tdata = rd_word_s[15:0];
      m_axis.tlast = rd_word_s[16];
      m_axis.tuser = rd_word_s[17];
    end else begin
      m_axis.tdata = 16'h0000;
      m_axis.tlast = 1'b0;
      m_axis.tuser = 1'b0;
    end
  end

  // Byte-pairing state machine.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r    <= WAIT_SOF;
      first_r    <= 8'h00;
      sof_pend_r <= 1'b0;
    end else if (s_axis.tvalid) begin
      case (state_r)
        WAIT_SOF, DROP: begin
          if (s_axis.tuser) begin
            first_r    <= s_axis.tdata;
            sof_pend_r <= 1'b1;
            state_r    <= SECOND;
          end
        end
        FIRST: begin
          if (!s_axis.tlast) begin
            first_r    <= s_axis.tdata;
            sof_pend_r <= s_axis.tuser;
            state_r    <= SECOND;
          end
        end
        SECOND: begin
          if (s_axis.tuser) begin
            first_r    <= s_axis.tdata;
            sof_pend_r <= 1'b1;
          end else if (push_s) begin
            state_r <= FIRST;
          end else begin
            state_r <= DROP;
          end
        end
        default: state_r <= WAIT_SOF;
      endcase
    end
  end

  // Pixel storage; pointers alone define validity, so the array needs no reset.
  always_ff @(posedge pclk) begin
    if (push_s) mem_r[wr_ptr_r] <= {sof_pend_r, s_axis.tlast, pix_data_s};
  end

  // FIFO pointers and registered valid.
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      tvalid_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r  <= count_nxt_s;
      tvalid_r <= (count_nxt_s != {(AW+1){1'b0}});
    end
  end

  // Sticky flags and statistics; SOF restarts the line count before the pixel's own line is counted.
  always_ff @(posedge pclk) begin
    if (rst) begin
      overflow_r    <= 1'b0;
      align_err_r   <= 1'b0;
      pix_cnt_r     <= {CNT_W{1'b0}};
      line_cnt_r    <= {CNT_W{1'b0}};
      line_pixels_r <= {CNT_W{1'b0}};
      frame_lines_r <= {CNT_W{1'b0}};
    end else begin
      if (drop_s)            overflow_r <= 1'b1;
      else if (clear_status) overflow_r <= 1'b0;
      if (align_set_s)       align_err_r <= 1'b1;
      else if (clear_status) align_err_r <= 1'b0;
      if (push_s) begin
        if (sof_pend_r) frame_lines_r <= line_cnt_r;
        if (s_axis.tlast) begin
          line_pixels_r <= pix_inc_s;
          pix_cnt_r     <= {CNT_W{1'b0}};
          line_cnt_r    <= sat_inc(line_base_s);
        end else begin
          pix_cnt_r  <= pix_inc_s;
          line_cnt_r <= line_base_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Directed bench for dvp_pixel_packer: vector table for the single-line cases, hand sequences
// for overflow, back-pressure ordering, mid-line reset and byte swap.
module tb_dvp_pixel_packer;

  logic        pclk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_last;
  logic        in_user;
  logic        rdy;
  logic        in_clr;
  logic        overflow, align_err;
  logic [11:0] line_pixels, frame_lines;
  logic        sw_overflow, sw_align_err;
  logic [11:0] sw_line_pixels, sw_frame_lines;

  int n_vec = 0;
  int n_bad = 0;

  dvp_pixel_packer_if #(.DW(8))  s_if ();
  dvp_pixel_packer_if #(.DW(16)) m_if ();
  dvp_pixel_packer_if #(.DW(8))  s_sw ();
  dvp_pixel_packer_if #(.DW(16)) m_sw ();

  assign s_if.tdata  = in_data;
  assign s_if.tvalid = in_vld;
  assign s_if.tlast  = in_last;
  assign s_if.tuser  = in_user;
  assign m_if.tready = rdy;
  assign s_sw.tdata  = in_data;
  assign s_sw.tvalid = in_vld;
  assign s_sw.tlast  = in_last;
  assign s_sw.tuser  = in_user;
  assign m_sw.tready = 1'b1;

  dvp_pixel_packer #(.BYTE_SWAP(0), .FIFO_DEPTH(16), .CNT_W(12)) u_dut (
    .pclk(pclk), .rst(rst), .s_axis(s_if), .m_axis(m_if), .clear_status(in_clr),
    .overflow(overflow), .align_err(align_err),
    .line_pixels(line_pixels), .frame_lines(frame_lines)
  );

  dvp_pixel_packer #(.BYTE_SWAP(1), .FIFO_DEPTH(16), .CNT_W(12)) u_dut_swap (
    .pclk(pclk), .rst(rst), .s_axis(s_sw), .m_axis(m_sw), .clear_status(in_clr),
    .overflow(sw_overflow), .align_err(sw_align_err),
    .line_pixels(sw_line_pixels), .frame_lines(sw_frame_lines)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        vld;
    logic [7:0]  d;
    logic        last;
    logic        user;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] edata;
    logic        elast;
    logic        euser;
    logic        ealign;
    logic [11:0] elp;
  } vec_t;

  vec_t        vecs [23];
  logic [17:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; in_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic user, input logic last);
    in_vld = 1'b1; in_data = d; in_user = user; in_last = last;
    tick();
    in_vld = 1'b0;
  endtask

  // One cycle of the back-pressure test: score a pixel that will handshake on this edge.
  task automatic step();
    if (m_if.tvalid && rdy) begin
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_extra: got %0h expected no pixel", m_if.tdata);
      end else begin
        chk("sb_pixel", {14'h0, m_if.tuser, m_if.tlast, m_if.tdata}, {14'h0, q.pop_front()});
      end
    end
    tick();
  endtask

  initial begin
    logic [7:0]  prev;
    logic [31:0] act;
    int          cyc;

    in_data = 8'h00; in_vld = 1'b0; in_last = 1'b0; in_user = 1'b0; rdy = 1'b1; in_clr = 1'b0;

    //            vld   d      last  user  rdy   clr   ev    edata     el    eu    ealign lp
    vecs[0]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b0, 1'b1, 1'b0, 12'd0};
    vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0304, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[7]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0506, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[8]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[9]  = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0708, 1'b1, 1'b0, 1'b0, 12'd4};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[11] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[12] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1112, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[13] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[14] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1314, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[15] = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[16] = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1516, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[17] = '{1'b1, 8'h17, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 12'd4};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[19] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};
    vecs[20] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2122, 1'b1, 1'b0, 1'b0, 12'd4};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2122, 1'b1, 1'b0, 1'b0, 12'd4};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 12'd4};

    do_reset();
    chk("reset_state", {m_if.tvalid, overflow, align_err, line_pixels, frame_lines}, 32'h0);

    for (int i = 0; i < 23; i++) begin
      in_vld = vecs[i].vld; in_data = vecs[i].d; in_last = vecs[i].last;
      in_user = vecs[i].user; rdy = vecs[i].rdy; in_clr = vecs[i].clr;
      tick();
      act = {m_if.tvalid,
             vecs[i].ev ? {m_if.tlast, m_if.tuser, m_if.tdata} : 18'h0,
             align_err, line_pixels};
      chk($sformatf("vec[%0d]", i), act,
          {vecs[i].ev, vecs[i].elast, vecs[i].euser, vecs[i].edata, vecs[i].ealign, vecs[i].elp});
    end
    in_vld = 1'b0; in_clr = 1'b0;

    // Overflow: 20 pixels into a 16-deep FIFO with no drain.
    do_reset();
    rdy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      send(8'(k), k == 0, k == 39);
      if (k == 31) chk("ovf_before_full", {31'h0, overflow}, 32'h0);
      if (k == 33) chk("ovf_set", {31'h0, overflow}, 32'h1);
    end
    chk("ovf_head", {13'h0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {13'h0, 3'b110, 16'h0001});
    tick();
    chk("ovf_head_stable", {13'h0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {13'h0, 3'b110, 16'h0001});
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain[%0d]", i), {13'h0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata},
          {13'h0, 1'b1, i == 0, 1'b0, 8'(2*i), 8'(2*i+1)});
      tick();
    end
    chk("ovf_drained", {31'h0, m_if.tvalid}, 32'h0);
    send(8'h40, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b0);
    chk("ovf_next_sof", {13'h0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {13'h0, 3'b110, 16'h4041});
    in_clr = 1'b1; tick(); in_clr = 1'b0;
    chk("ovf_clear", {31'h0, overflow}, 32'h0);

    // Toggling tready over 3 frames of 4 lines x 6 pixels.
    do_reset();
    cyc = 0; prev = 8'h00;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) begin
        for (int b = 0; b < 12; b++) begin
          in_vld = 1'b1; in_data = 8'(f*48 + l*12 + b);
          in_user = (l == 0 && b == 0); in_last = (b == 11);
          rdy = 1'(cyc % 2);
          if (b % 2 == 1) q.push_back({(l == 0 && b == 1), (b == 11), prev, in_data});
          else            prev = in_data;
          step();
          cyc++;
          if (f == 1 && l == 0 && b == 1) chk("frame_lines_2nd_sof", {20'h0, frame_lines}, 32'd4);
        end
      end
    end
    in_vld = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 40 && q.size() > 0; k++) step();
    chk("toggle_all_out", q.size(), 32'd0);
    chk("toggle_stats", {m_if.tvalid, overflow, line_pixels, frame_lines}, {8'h0, 12'd6, 12'd4});

    // Mid-line reset, then restart on the next SOF; swapped instance checked here too.
    rdy = 1'b0;
    send(8'h60, 1'b1, 1'b0);
    send(8'h61, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'h0, m_if.tvalid}, 32'h1);
    send(8'h62, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_midline", {31'h0, m_if.tvalid}, 32'h0);
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(8'(8'h63 + k), 1'b0, 1'b0);
      chk($sformatf("post_rst_ignore[%0d]", k), {31'h0, m_if.tvalid}, 32'h0);
    end
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    chk("restart_sof", {13'h0, m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {13'h0, 3'b110, 16'hAABB});
    chk("byte_swap", {13'h0, m_sw.tvalid, m_sw.tuser, m_sw.tlast, m_sw.tdata}, {13'h0, 3'b110, 16'hBBAA});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
